// File: rtl/alu_arbiter.sv
// ============================================================================
// alu_arbiter: round-robin sharing of one combinational ALU between two
// requesters, with registered ALU inputs and a valid/ready response channel.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  // requester 0
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  // requester 1
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  // shared ALU
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  // responses
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_data,
  // status
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   last_grant;
  logic   winner;
  logic   accept;
  logic   rsp_take;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    winner = 1'b0;
    if (req0_valid && req1_valid) begin
      winner = ~last_grant;
    end else if (req1_valid) begin
      winner = 1'b1;
    end
  end

  assign req0_ready = rst_n & (state == IDLE) & req0_valid & ~winner;
  assign req1_ready = rst_n & (state == IDLE) & req1_valid &  winner;
  assign accept     = req0_ready | req1_ready;
  assign busy       = (state != IDLE);
  assign rsp_take   = owner ? rsp1_ready : rsp0_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_data   <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_a      <= winner ? req1_a  : req0_a;
            alu_b      <= winner ? req1_b  : req0_b;
            alu_op     <= winner ? req1_op : req0_op;
            owner      <= winner;
            last_grant <= winner;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_data   <= alu_result;
          rsp0_valid <= ~owner;
          rsp1_valid <=  owner;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_take) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          rsp0_valid <= 1'b0;
          rsp1_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational `alu` datapath between two requesters, for example the integer pipeline and a debug/CSR port. It runs round-robin arbitration, registers the winner's operands and op_code onto the ALU inputs, and captures the ALU result. It returns the result to the winner through a valid/ready response channel. Only one operation is in flight at a time.

## Interface
Parameters:
- DATA_W, 32, operand/result width; must match the ALU (32).
- OP_W, 4, ALU op_code width; the code is passed through unchanged.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  in  DATA_W  requester 0 operands.
- req0_op  in  OP_W  requester 0 ALU op_code.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0, for requester 1.
- alu_a, alu_b  out  DATA_W  registered operands to ALU input_a/input_b.
- alu_op  out  OP_W  registered op_code to ALU.
- alu_result  in  DATA_W  ALU result (combinational from alu_a/alu_b/alu_op).
- rsp0_valid  out  1  result for requester 0 available.
- rsp0_ready  in  1  requester 0 takes the result.
- rsp1_valid, rsp1_ready: same as rsp0, for requester 1.
- rsp_data  out  DATA_W  result; shared by both response channels.
- busy  out  1  state != IDLE.
- owner  out  1  index of the requester currently being served (last accepted).

## Operation
- FSM states: IDLE, EXEC, RESP.
  - IDLE: compute the winner. On req handshake (valid & ready): latch a/b/op into alu_a/alu_b/alu_op, set owner to the winner index, set last_grant to the winner index, go to EXEC.
  - EXEC: one cycle. At the edge, capture alu_result into rsp_data, assert rsp<owner>_valid, go to RESP.
  - RESP: hold rsp_data and rsp<owner>_valid stable until rsp<owner>_ready=1. At that edge, clear valid and go to IDLE. rsp ready of the non-owner is ignored.
- Arbitration (IDLE only):
  - Only one valid: that requester wins.
  - Both valid: the requester != last_grant wins.
  - last_grant resets to 1, so requester 0 wins the first tie.
- reqN_ready = (state==IDLE) & reqN_valid & (winner==N). At most one ready is high per cycle. ready depends combinationally on valid; requesters must not derive valid from ready.
- Requesters hold valid, a, b and op stable until their ready is high. Withdrawing valid before acceptance is illegal.
- No request is accepted in EXEC or RESP, including the cycle of the response handshake.
- alu_a, alu_b and alu_op hold their last accepted values outside EXEC. They change only on acceptance.
- Width rules: no arithmetic in this block. Result bits pass through unmodified. Signedness and shift-amount truncation belong to the ALU.
- Reset (any state, including mid-EXEC/RESP): the operation is aborted and no response is produced.
  - State = IDLE, last_grant = 1, owner = 0.
  - alu_a = alu_b = 0, alu_op = 0, rsp_data = 0.
  - rsp0_valid = rsp1_valid = 0, busy = 0.
  - req ready outputs are combinationally 0 while rst_n=0.

## Timing
- Accept at edge N (end of the handshake cycle). Cycle N+1 is EXEC, with alu_* updated. rsp valid is high from cycle N+2.
- Minimum latency from request handshake to response valid: 2 cycles.
- Minimum issue interval: 3 cycles (accept, EXEC, RESP with ready=1). The next accept is possible in the cycle after the response handshake.
- Response back-pressure: the FSM stalls in RESP indefinitely with rsp_data unchanged. Other requests wait with ready=0.
- Simultaneous events:
  - req valid rising in the same cycle as a response handshake: not accepted until IDLE.
  - Both valid in IDLE: exactly one granted, per the round-robin rule.
- busy is high from cycle N+1 through the last RESP cycle.

## Test plan
- Single request, ADD op code, req0 a=5, b=3, rsp0_ready=1 → req0_ready high in the valid cycle. rsp0_valid and rsp_data=8 two cycles later for exactly 1 cycle; rsp1_valid stays 0.
- Both requesters valid from reset, req0 SUB 10-4 and req1 XOR 0xF0^0x0F, responses always ready → req0 served first (rsp0 data 6), then req1 (rsp1 data 0xFF). Accepts are 3 cycles apart.
- Both requesters continuously valid for 6 operations → grants alternate 0,1,0,1,0,1. owner matches each response channel.
- req0 accepted, rsp0_ready held 0 for 4 cycles while req1 is valid → rsp_data stable, req1_ready stays 0. req1 is accepted the cycle after rsp0 handshake, then responded.
- rst_n asserted low during EXEC of a req1 op → all outputs go to reset values immediately. No rsp1_valid after release. The next tie is granted to req0.
- rsp1_ready pulsed while requester 0 owns the response → ignored, and rsp0_valid is held.
